// File: rtl/dstdata_pkg.sv
// Shared parameters and helpers for the destination data buffer.
// Optional macro DSTDATA_BYPASS_EN enables empty-FIFO forwarding in dstdata_buf.
package dstdata_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dstdata_ram.sv
// Destination data storage: one synchronous write port,
// one asynchronous read port.
module dstdata_ram
  import dstdata_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dstdata_buf.sv
// Blitter destination data FIFO with optional half-width packing.
// Define DSTDATA_BYPASS_EN to forward a load into an empty FIFO.
module dstdata_buf
  import dstdata_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      MasterClock,
  input  logic                      RESET,
  input  logic [WIDTH-1:0]          ID,
  input  logic                      LDDST,
  input  logic                      PACK,
  input  logic                      DSTRD,
  input  logic                      CLROVF,
  output logic [WIDTH-1:0]          DSTD,
  output logic                      DSTV,
  output logic                      FULL,
  output logic [cnt_w(DEPTH)-1:0]   COUNT,
  output logic                      OVF
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = WIDTH / 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [HW-1:0]    half;
  logic             half_v;
  logic             ovf;
  logic [WIDTH-1:0] entry;
  logic [WIDTH-1:0] head;
  logic             complete;
  logic             stored_v;
  logic             is_full;
  logic             pop;
  logic             push;
  logic             wr_en;

  assign complete = LDDST && (!PACK || half_v);
  assign entry    = PACK ? {ID[HW-1:0], half} : ID;
  assign stored_v = cnt != '0;
  assign is_full  = cnt == FULL_CNT;
  assign pop      = DSTRD && stored_v;
  assign push     = complete && (!is_full || DSTRD);

`ifdef DSTDATA_BYPASS_EN
  logic bypass;
  assign bypass = complete && !stored_v;
  // A forwarded entry popped in the same cycle never reaches the RAM
  assign wr_en  = push && !(bypass && DSTRD);
  assign DSTV   = stored_v || bypass;
  assign DSTD   = stored_v ? head : (bypass ? entry : '0);
`else
  assign wr_en  = push;
  assign DSTV   = stored_v;
  assign DSTD   = stored_v ? head : '0;
`endif

  assign FULL  = is_full;
  assign COUNT = cnt;
  assign OVF   = ovf;

  dstdata_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (MasterClock),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (entry),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      half   <= '0;
      half_v <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      if (!PACK) begin
        half_v <= 1'b0;
      end else if (LDDST) begin
        if (!half_v) begin
          half   <= ID[HW-1:0];
          half_v <= 1'b1;
        end else begin
          half_v <= 1'b0;
        end
      end
      if (CLROVF)                ovf <= 1'b0;
      else if (complete && !push) ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dstdata_buf.sv
// Scoreboard bench for dstdata_buf (WIDTH=8, DEPTH=4).
module tb_dstdata_buf;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             MasterClock;
  logic             RESET;
  logic [WIDTH-1:0] ID;
  logic             LDDST;
  logic             PACK;
  logic             DSTRD;
  logic             CLROVF;
  logic [WIDTH-1:0] DSTD;
  logic             DSTV;
  logic             FULL;
  logic [2:0]       COUNT;
  logic             OVF;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] q[$];

  dstdata_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .MasterClock (MasterClock),
    .RESET       (RESET),
    .ID          (ID),
    .LDDST       (LDDST),
    .PACK        (PACK),
    .DSTRD       (DSTRD),
    .CLROVF      (CLROVF),
    .DSTD        (DSTD),
    .DSTV        (DSTV),
    .FULL        (FULL),
    .COUNT       (COUNT),
    .OVF         (OVF)
  );

  initial MasterClock = 1'b0;
  always #5 MasterClock = ~MasterClock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge MasterClock);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v, input logic pk);
    ID    = v;
    PACK  = pk;
    LDDST = 1'b1;
    cycle();
    LDDST = 1'b0;
  endtask

  task automatic drain();
    logic [WIDTH-1:0] exp;
    int guard = 0;
    while (q.size() > 0 && guard < DEPTH + 4) begin
      exp = q.pop_front();
      check("pop_dstv", 32'(DSTV), 32'd1);
      check("pop_data", 32'(DSTD), 32'(exp));
      DSTRD = 1'b1;
      cycle();
      DSTRD = 1'b0;
      guard++;
    end
    if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    check("drained_count", 32'(COUNT), 32'd0);
    check("drained_dstv", 32'(DSTV), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET  = 1'b1;
    ID     = '0;
    LDDST  = 1'b0;
    PACK   = 1'b0;
    DSTRD  = 1'b0;
    CLROVF = 1'b0;
    cycle();
    cycle();
    check("rst_count", 32'(COUNT), 32'd0);
    check("rst_dstv", 32'(DSTV), 32'd0);
    check("rst_dstd", 32'(DSTD), 32'd0);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_ovf", 32'(OVF), 32'd0);
    RESET = 1'b0;
    cycle();

    // fill in plain mode
    for (int i = 0; i < DEPTH; i++) begin
      logic [WIDTH-1:0] v;
      v = WIDTH'(8'h11 * (i + 1));
      load(v, 1'b0);
      q.push_back(v);
      if (i == 0) begin
        check("lat1_dstv", 32'(DSTV), 32'd1);
        check("lat1_dstd", 32'(DSTD), 32'h11);
      end
    end
    check("fill_full", 32'(FULL), 32'd1);
    check("fill_count", 32'(COUNT), 32'd4);

    // overflow then clear with a competing overflow
    load(8'h55, 1'b0);
    check("ovf_set", 32'(OVF), 32'd1);
    check("ovf_count", 32'(COUNT), 32'd4);
    CLROVF = 1'b1;
    load(8'h56, 1'b0);
    CLROVF = 1'b0;
    check("ovf_clr", 32'(OVF), 32'd0);
    check("ovf_head", 32'(DSTD), 32'h11);

    // push and pop together while full
    check("pp_head", 32'(DSTD), 32'(q.pop_front()));
    DSTRD = 1'b1;
    load(8'h77, 1'b0);
    DSTRD = 1'b0;
    q.push_back(8'h77);
    check("pp_count", 32'(COUNT), 32'd4);
    check("pp_full", 32'(FULL), 32'd1);
    check("pp_ovf", 32'(OVF), 32'd0);
    drain();

    // pop while empty must not underflow
    DSTRD = 1'b1;
    cycle();
    DSTRD = 1'b0;
    check("under_count", 32'(COUNT), 32'd0);
    check("under_full", 32'(FULL), 32'd0);

    // pack two halves
    load(8'hA3, 1'b1);
    check("pack_half_dstv", 32'(DSTV), 32'd0);
    load(8'h5C, 1'b1);
    PACK = 1'b0;
    q.push_back(8'hC3);
    check("pack_count", 32'(COUNT), 32'd1);
    drain();

    // PACK low discards a held half
    load(8'h07, 1'b1);
    PACK = 1'b0;
    cycle();
    load(8'h09, 1'b1);
    load(8'h0B, 1'b1);
    PACK = 1'b0;
    q.push_back(8'hB9);
    check("drop_count", 32'(COUNT), 32'd1);
    drain();

    // reset mid-pack with two entries stored, competing strobes
    load(8'h01, 1'b0);
    load(8'h02, 1'b0);
    load(8'h0F, 1'b1);
    RESET = 1'b1;
    ID    = 8'hEE;
    LDDST = 1'b1;
    DSTRD = 1'b1;
    cycle();
    RESET = 1'b0;
    LDDST = 1'b0;
    DSTRD = 1'b0;
    q.delete();
    check("mrst_count", 32'(COUNT), 32'd0);
    check("mrst_dstv", 32'(DSTV), 32'd0);
    check("mrst_dstd", 32'(DSTD), 32'd0);
    load(8'h0A, 1'b1);
    load(8'h0B, 1'b1);
    PACK = 1'b0;
    q.push_back(8'hBA);
    drain();

    // load into empty: same-cycle view depends on the bypass build
    ID    = 8'h66;
    PACK  = 1'b0;
    LDDST = 1'b1;
    #1;
`ifdef DSTDATA_BYPASS_EN
    check("byp_dstv", 32'(DSTV), 32'd1);
    check("byp_dstd", 32'(DSTD), 32'h66);
`else
    check("nobyp_dstv", 32'(DSTV), 32'd0);
    check("nobyp_dstd", 32'(DSTD), 32'd0);
`endif
    cycle();
    LDDST = 1'b0;
    q.push_back(8'h66);
    check("e66_count", 32'(COUNT), 32'd1);
    drain();

`ifdef DSTDATA_BYPASS_EN
    ID    = 8'h5A;
    LDDST = 1'b1;
    DSTRD = 1'b1;
    #1;
    check("bypc_dstd", 32'(DSTD), 32'h5A);
    cycle();
    LDDST = 1'b0;
    DSTRD = 1'b0;
    check("bypc_count", 32'(COUNT), 32'd0);
    check("bypc_dstv", 32'(DSTV), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dstdata_buf.md
DSTDATA_BUF -- requirements
Module: dstdata_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 8: destination data width in bits; even, at least 4.
REQ-002 SHALL have parameter DEPTH, default 4: buffer entries; power of two, at least 2.
REQ-003 SHALL have port MasterClock  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port ID  in  WIDTH  internal data bus carrying load data.
REQ-006 SHALL have port LDDST  in  1  load strobe, active-high, one load per cycle asserted.
REQ-007 SHALL have port PACK  in  1  pack mode; two half-width loads form one entry.
REQ-008 SHALL have port DSTRD  in  1  pop strobe from the blitter write path.
REQ-009 SHALL have port CLROVF  in  1  clears OVF.
REQ-010 SHALL have port DSTD  out  WIDTH  head entry data.
REQ-011 SHALL have port DSTV  out  1  DSTD valid (buffer non-empty).
REQ-012 SHALL have port FULL  out  1  COUNT equals DEPTH.
REQ-013 SHALL have port COUNT  out  $clog2(DEPTH+1)  stored entries.
REQ-014 SHALL have port OVF  out  1  sticky flag: an entry was dropped.

Function
REQ-015 SHALL implement a FIFO of DEPTH entries with wrap-around read and write pointers; DSTD presents the head entry.
REQ-016 SHALL, with PACK low, make each LDDST a complete entry equal to ID.
REQ-017 SHALL, with PACK high, latch ID[WIDTH/2-1:0] into a half register on the first LDDST, with half-valid set.
REQ-018 SHALL, with PACK high, form an entry on the second LDDST as {ID[WIDTH/2-1:0], held half}, then clear half-valid.
REQ-019 SHALL clear half-valid, discarding the held half, on any cycle PACK is low.
REQ-020 SHALL accept a complete entry when FULL is low, or when FULL is high and DSTRD is asserted in the same cycle.
REQ-021 SHALL drop any other complete entry and set OVF; the FIFO contents are not modified.
REQ-022 SHALL ignore DSTRD while DSTV is low; COUNT never underflows.
REQ-023 SHALL, on a simultaneous accepted push and pop, leave COUNT unchanged and advance both pointers.
REQ-024 SHALL give CLROVF priority over a same-cycle overflow; OVF reads 0 afterwards.
REQ-025 SHALL give a stored entry a latency of 1 cycle from its completing LDDST to DSTD/DSTV, unless REQ-029 applies.
REQ-026 SHALL update COUNT, FULL and DSTV in the cycle after the push or pop that causes the change.

Reset
REQ-027 SHALL, on RESET high at a clock edge, clear pointers, COUNT, half-valid and OVF, and drive DSTD=0, DSTV=0, FULL=0.
REQ-028 SHALL give RESET priority over a same-cycle LDDST, DSTRD or CLROVF; a partly packed entry is discarded.

Configuration
REQ-029 SHALL, with DSTDATA_BYPASS_EN defined, forward a completing load into an empty FIFO combinationally: DSTD=entry and DSTV=1 in the same cycle.
REQ-030 SHALL, with DSTDATA_BYPASS_EN defined, consume a bypassed entry without storing it when DSTRD is asserted in that cycle; COUNT stays 0.
REQ-031 SHALL, without DSTDATA_BYPASS_EN, have no combinational path from ID or LDDST to any output.

Structure
REQ-032 SHALL place the WIDTH/DEPTH defaults and a count-width helper function in package dstdata_pkg.
REQ-033 SHALL implement the storage array as sub-module dstdata_ram: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.

Verification
REQ-034 SHALL cover: WIDTH=8, DEPTH=4, PACK=0; load 0x11,0x22,0x33,0x44 -> FULL=1, COUNT=4; four pops return 0x11..0x44 in order.
REQ-035 SHALL cover: full buffer, load 0x55 without DSTRD -> OVF=1, COUNT=4; then CLROVF -> OVF=0.
REQ-036 SHALL cover: PACK=1, load 0xA3 then 0x5C -> one entry, DSTD=0xC3.
REQ-037 SHALL cover: PACK=1, load 0x07, drop PACK for one cycle, then load 0x09 and 0x0B with PACK=1 -> single entry 0xB9.
REQ-038 SHALL cover: full buffer, LDDST and DSTRD in the same cycle -> COUNT stays 4, new data at tail, no OVF.
REQ-039 SHALL cover: RESET asserted mid-pack with two entries stored -> next cycle COUNT=0, DSTV=0, DSTD=0; with the bypass macro defined, a load of 0x66 into empty shows DSTD=0x66 in the same cycle.
